// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundle (instruction memory, redirect, decode handshake)
//   master : the fetch unit (drives im_req/im_addr and the id_* outputs)
//   slave  : the environment (memory, execute redirect, decoder)
interface fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    modport master (
        output im_req, im_addr, id_valid, id_instr, id_pc,
        input  im_gnt, im_rvalid, im_rdata, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  im_req, im_addr, id_valid, id_instr, id_pc,
        output im_gnt, im_rvalid, im_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC generation, in-order buffer and redirect flush
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   bus (master)   : im_req/im_addr/im_gnt/im_rvalid/im_rdata memory side,
//                    redirect_valid/redirect_pc from execute,
//                    id_valid/id_ready/id_instr/id_pc towards decode
//   FETCH_PERF_EN  : when defined, adds perf_fetch_cnt (pops) and perf_flush_cnt (redirect cycles)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_flush_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = 16;
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_outstanding;
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;
    logic [DW-1:0] r_drop_cnt;
    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]   r_tag_pc     [FIFO_DEPTH];

    logic [PW-1:0] w_occ;
    logic [PW:0]   w_inflight;
    logic          w_empty;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_inflight = {1'b0, w_occ} + {1'b0, r_outstanding};
    assign w_empty    = r_wr_ptr == r_rd_ptr;

    // Gating with rst keeps the request low while reset is held, and lets it rise
    // as soon as reset is released.
    assign bus.im_req  = rst && !bus.redirect_valid && (w_inflight < DEPTH);
    assign bus.im_addr = r_fetch_pc;

    assign w_issue = bus.im_req && bus.im_gnt;
    assign w_drop  = bus.im_rvalid && (r_drop_cnt != '0);
    assign w_push  = bus.im_rvalid && (r_drop_cnt == '0) && !bus.redirect_valid;
    assign w_pop   = !w_empty && bus.id_ready && !bus.redirect_valid;

    assign bus.id_valid = !w_empty;
    assign bus.id_instr = w_empty ? NOP   : r_fifo_instr[r_rd_ptr[AW-1:0]];
    assign bus.id_pc    = w_empty ? '0    : r_fifo_pc[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            // Every request still in flight will return a stale word that must be discarded;
            // a word arriving this very cycle is already consumed by the flush.
            r_fetch_pc    <= bus.redirect_pc & ~32'h3;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + DW'(r_outstanding) - DW'(bus.im_rvalid);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag_wr   <= r_tag_wr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_drop)
                r_drop_cnt <= r_drop_cnt - DW'(1);
            r_outstanding <= r_outstanding + PW'(w_issue) - PW'(w_push);
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_issue)
            r_tag_pc[r_tag_wr] <= r_fetch_pc;
        if (w_push) begin
            r_fifo_instr[r_wr_ptr[AW-1:0]] <= bus.im_rdata;
            r_fifo_pc[r_wr_ptr[AW-1:0]]    <= r_tag_pc[r_tag_rd];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          CYCLES   = 3000;
    localparam int          MID_RST  = 1500;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    fetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    rsp_t        mem_q[$];
    logic [31:0] m_issue_pc;
    int          cyc = 0;
    bit          run = 0;
    int          m_pops = 0;
    int          m_perf_pops = 0;
    int          m_perf_flush = 0;
    bit          mon_prev_redir = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_im_req"},   {31'd0, bus.im_req},   32'd0);
        chk({tag, "_id_valid"}, {31'd0, bus.id_valid}, 32'd0);
        chk({tag, "_id_instr"}, bus.id_instr, NOP);
        chk({tag, "_id_pc"},    bus.id_pc, 32'd0);
        chk({tag, "_im_addr"},  bus.im_addr, RESET_PC);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
        chk({tag, "_perf_flush"}, perf_flush_cnt, 32'd0);
`endif
    endtask

    task automatic idle_inputs();
        bus.im_gnt         = 1'b0;
        bus.im_rvalid      = 1'b0;
        bus.im_rdata       = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.id_ready       = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_q.delete();
        m_issue_pc   = RESET_PC;
        m_perf_pops  = 0;
        m_perf_flush = 0;
    endtask

    // Monitor: checks every decode-side handshake against the expected-PC queue.
    always begin
        @(negedge clk);
        #2;
        if (run) begin
            if (mon_prev_redir)
                chk("valid_after_redirect", {31'd0, bus.id_valid}, 32'd0);
            if (!bus.id_valid) begin
                chk("idle_instr", bus.id_instr, NOP);
                chk("idle_pc", bus.id_pc, 32'd0);
            end else if (bus.id_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got pc %h expected no instruction", bus.id_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("id_pc", bus.id_pc, e);
                    chk("id_instr", bus.id_instr, mem_word(e));
                    m_pops++;
                    m_perf_pops++;
                end
            end
            mon_prev_redir = bus.redirect_valid;
        end else begin
            mon_prev_redir = 1'b0;
        end
    end

    // Driver: memory model, redirect and stall stimulus, issue-side checks.
    initial begin
        int rdy_mode;
        int gnt_mode;
        bit prev_redir;
        bit redir;
        bit hold;
        logic [31:0] tgt;
        rst = 1'b0;
        idle_inputs();
        rdy_mode   = 0;
        gnt_mode   = 0;
        prev_redir = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        while (cyc < CYCLES) begin
            @(negedge clk);
            cyc++;
            if (cyc == MID_RST) begin
                run = 1'b0;
                rst = 1'b0;
                idle_inputs();
                #1;
                chk_reset_outputs("mid_reset");
                model_reset();
                prev_redir = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                run = 1'b1;
                continue;
            end
            if (cyc % 64 == 0) begin
                rdy_mode = $urandom_range(0, 2);
                gnt_mode = $urandom_range(0, 1);
            end
            // Just before the mid-run reset, stall decode so the buffer is holding entries.
            hold = (cyc >= MID_RST - 30) && (cyc < MID_RST);
            redir = 1'b0;
            tgt   = 32'd0;
            if (!hold && ($urandom_range(0, 19) == 0 || (prev_redir && $urandom_range(0, 2) == 0))) begin
                redir = 1'b1;
                case ($urandom_range(0, 3))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
                    2:       tgt = 32'h0000_0102;
                    default: tgt = 32'($urandom_range(0, 4095));
                endcase
            end
            prev_redir         = redir;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            bus.id_ready       = hold ? 1'b0 : (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && (hold || gnt_mode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.im_rvalid = 1'b1;
                bus.im_rdata  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                bus.im_rvalid = 1'b0;
                bus.im_rdata  = $urandom;
            end
            #1;
            chk("im_req", {31'd0, bus.im_req}, {31'd0, (!redir && exp_q.size() < DEPTH)});
            bus.im_gnt = (hold || gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (redir) begin
                exp_q.delete();
                m_issue_pc = tgt & ~32'h3;
                m_perf_flush++;
            end else if (bus.im_req && bus.im_gnt) begin
                chk("im_addr", bus.im_addr, m_issue_pc);
                exp_q.push_back(m_issue_pc);
                mem_q.push_back('{addr: bus.im_addr, due: cyc + 1});
                m_issue_pc = m_issue_pc + 32'd4;
            end
        end
        @(negedge clk);
        idle_inputs();
        #3;
        chk("progress", {31'd0, m_pops > 500}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_perf_pops));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(m_perf_flush));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
